// File: rtl/fp_pkg.sv
`default_nettype none
// fp_pkg: shared constants, FSM encoding and packed-float field offsets for the FP normalizer.
// Rev 1.0 -- FP_NORM_ROUND_EN adds the ROUND state.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int GRS_W  = 3;
  localparam int BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = MANT_W;
  localparam int SIGN_BIT = EXP_W + MANT_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NORM  = 3'd1,
    ST_PACK  = 3'd2,
`ifdef FP_NORM_ROUND_EN
    ST_OUT   = 3'd3,
    ST_ROUND = 3'd4
`else
    ST_OUT   = 3'd3
`endif
  } state_t;
endpackage
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// fp_round_rne: combinational round-to-nearest-even of {exp, significand, GRS}.
// Rev 1.0 -- used only when FP_NORM_ROUND_EN is defined.
module fp_round_rne #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int GRS_W  = 3
) (
  input  logic [EXP_W:0]    exp_in,
  input  logic [MANT_W:0]   sig_in,
  input  logic [GRS_W-1:0]  grs_in,
  output logic [EXP_W:0]    exp_out,
  output logic [MANT_W-1:0] frac_out,
  output logic              overflow
);
  logic              round_up;
  logic [MANT_W+1:0] sum;

  always_comb begin
    round_up = grs_in[GRS_W-1] & ((|grs_in[GRS_W-2:0]) | sig_in[0]);
    sum      = {1'b0, sig_in} + (MANT_W+2)'(round_up);
    exp_out  = exp_in;
    frac_out = sum[MANT_W-1:0];
    if (sum[MANT_W+1]) begin
      exp_out  = exp_in + (EXP_W+1)'(1);
      frac_out = sum[MANT_W:1];
    end else if (!sig_in[MANT_W] && sum[MANT_W]) begin
      // a denormal that rounds up into the normal range gains exponent 1
      exp_out = exp_in + (EXP_W+1)'(1);
    end
    overflow = (exp_out >= {1'b0, {EXP_W{1'b1}}});
  end
endmodule
`default_nettype wire

// File: rtl/fp_sub_normalizer.sv
`default_nettype none
// fp_sub_normalizer: one-bit-per-cycle normalize and pack after FP subtraction.
// Rev 1.0 -- define FP_NORM_ROUND_EN for RNE rounding (adds a ROUND cycle); default truncates.
module fp_sub_normalizer #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int GRS_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W+GRS_W+1:0] in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   out_result
);
  import fp_pkg::*;

  localparam int MX_W = MANT_W + GRS_W + 2;
  localparam logic [EXP_W:0] EXP_LIM = {1'b0, {EXP_W{1'b1}}};

  state_t              state, state_nxt;
  logic                sign_q;
  logic [EXP_W:0]      exp_q;
  logic [EXP_W:0]      exp_inc;
  logic [MX_W-1:0]     mant_q;
  logic                ovf_q;
  logic                is_zero, has_carry, has_hidden, at_floor;
  logic [EXP_W+MANT_W:0] packed_w;

  assign exp_inc    = exp_q + (EXP_W+1)'(1);
  assign is_zero    = (mant_q == '0);
  assign has_carry  = mant_q[MX_W-1];
  assign has_hidden = mant_q[MX_W-2];
  assign at_floor   = (exp_q <= (EXP_W+1)'(1));
  assign packed_w   = ovf_q ? {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}}
                            : {sign_q, exp_q[EXP_W-1:0], mant_q[MX_W-3:GRS_W]};

`ifdef FP_NORM_ROUND_EN
  logic [EXP_W:0]    rnd_exp;
  logic [MANT_W-1:0] rnd_frac;
  logic              rnd_ovf;

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W),
    .GRS_W  (GRS_W)
  ) u_round (
    .exp_in   (exp_q),
    .sig_in   (mant_q[MX_W-2:GRS_W]),
    .grs_in   (mant_q[GRS_W-1:0]),
    .exp_out  (rnd_exp),
    .frac_out (rnd_frac),
    .overflow (rnd_ovf)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_NORM;
      end
      ST_NORM: begin
        if (is_zero || has_carry || has_hidden || at_floor) state_nxt = ST_PACK;
      end
`ifdef FP_NORM_ROUND_EN
      ST_PACK:  state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_OUT;
`else
      ST_PACK:  state_nxt = ST_OUT;
`endif
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      ovf_q      <= 1'b0;
      out_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= {1'b0, in_exp};
            mant_q <= in_mant;
            ovf_q  <= 1'b0;
          end
        end
        ST_NORM: begin
          if (is_zero) begin
            sign_q <= 1'b0;
            exp_q  <= '0;
          end else if (has_carry) begin
            // shifted-out bit folds into sticky
            mant_q <= {1'b0, mant_q[MX_W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_inc;
            if (exp_inc >= EXP_LIM) ovf_q <= 1'b1;
          end else if (has_hidden) begin
            exp_q <= exp_q;
          end else if (at_floor) begin
            exp_q <= '0;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - (EXP_W+1)'(1);
          end
        end
`ifdef FP_NORM_ROUND_EN
        ST_PACK: begin
          if (!ovf_q) begin
            exp_q                 <= rnd_exp;
            mant_q[MX_W-3:GRS_W] <= rnd_frac;
            ovf_q                 <= rnd_ovf;
          end
        end
        ST_ROUND: out_result <= packed_w;
`else
        ST_PACK: out_result <= packed_w;
`endif
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fp_sub_normalizer.sv
`default_nettype none
// tb_fp_sub_normalizer: directed and randomized checks of fp_sub_normalizer against a value-level model.
// Rev 1.0 -- honours FP_NORM_ROUND_EN.
module tb_fp_sub_normalizer;
`ifdef FP_NORM_ROUND_EN
  localparam int RL = 1;
  localparam logic [31:0] ROUND_RES = 32'h3F800002;
`else
  localparam int RL = 0;
  localparam logic [31:0] ROUND_RES = 32'h3F800001;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_sub_normalizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Value-level model: find the leading one, shift as far as the exponent allows, then pack.
  function automatic void ref_model(input logic s, input int e, input logic [27:0] m,
                                    output logic [31:0] r, output int lat);
    int unsigned mv, sig;
    int ex, p, need, avail, sh;
    mv = m; ex = e; sh = 0; p = 0;
    if (mv == 0) begin
      r = 32'h0; lat = 2 + RL;
      return;
    end
    if (mv[27]) begin
      mv = (mv >> 1) | (mv & 1);
      ex = ex + 1;
    end else begin
      for (int i = 0; i < 28; i++) if (mv[i]) p = i;
      need  = 26 - p;
      avail = (ex > 1) ? ex - 1 : 0;
      if (need <= avail) begin sh = need;  ex = ex - need; end
      else               begin sh = avail; ex = 0;         end
      mv = mv << sh;
    end
    sig = mv >> 3;
`ifdef FP_NORM_ROUND_EN
    if (mv[2] && ((mv & 3) != 0 || sig[0])) begin
      sig = sig + 1;
      if (sig == (1 << 24)) begin sig = sig >> 1; ex = ex + 1; end
      else if (ex == 0 && sig >= (1 << 23)) ex = 1;
    end
`endif
    if (ex >= 255) r = {s, 8'hFF, 23'h0};
    else           r = {s, ex[7:0], sig[22:0]};
    lat = 2 + sh + RL;
  endfunction

  task automatic do_case(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                         input logic [31:0] exp_res, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_mant = ~m;
    chk({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, out_result, exp_res);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_result"}, out_result, exp_res);
      chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] r;
    int          lat;
    int          hold;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_result", out_result, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    do_case("cancel",    1'b0, 8'd127, 28'h0400000, 32'h3D800000, 6 + RL, 0);
    do_case("carry",     1'b0, 8'd130, 28'hC000000, 32'h41C00000, 2 + RL, 0);
    do_case("carry_inf", 1'b0, 8'd254, 28'hC000000, 32'h7F800000, 2 + RL, 0);
    do_case("zero",      1'b1, 8'd130, 28'h0000000, 32'h00000000, 2 + RL, 0);
    do_case("denorm",    1'b0, 8'd3,   28'h0080000, 32'h00040000, 4 + RL, 0);
    do_case("round",     1'b0, 8'd127, 28'h400000C, ROUND_RES,    2 + RL, 0);
    do_case("backpress", 1'b1, 8'd127, 28'h0400000, 32'hBD800000, 6 + RL, 5);

    // reset while normalizing
    @(negedge clk);
    in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h0400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_result", out_result, 32'h0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_stays_idle", 32'(out_valid), 32'd0);

    for (int n = 0; n < 60; n++) begin
      s = 1'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 254));
      m = ($urandom_range(0, 9) == 0) ? 28'h0 : 28'($urandom) >> $urandom_range(0, 27);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      ref_model(s, int'(e), m, r, lat);
      do_case("rand", s, e, m, r, lat, hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
